apb_regfile: RTL and testbench
==============================

// Module: apb_regfile
// PURPOSE
//  APB completer: the downstream consumer of the apb requester's paddr/psel/penable/pwrite/pwdata/pstrb bus.
//  Provides a small word-addressed register bank with programmable wait states and slave errors.
//  Reg 0 = read-only ID, reg 1 = read-only hardware status, regs 2..NUM_REGS-1 = RW control regs exported to logic.
// PARAMETERS
//  ADDR_WIDTH   32           paddr width
//  DATA_WIDTH   32           data width; multiple of 8
//  NUM_REGS     8            register count, >=3; index width IDX_W = $clog2(NUM_REGS)
//  WAIT_STATES  1            access-phase cycles with pready=0 before completion (0..15)
//  ID_VALUE     32'h0A9B_0001  read value of reg 0
// PORTS
//  pclk        in   1                      clock
//  presetn     in   1                      async reset, active low
//  paddr       in   ADDR_WIDTH             byte address
//  pprot       in   3                      ignored
//  pnse        in   1                      ignored
//  psel        in   1                      select
//  penable     in   1                      access phase
//  pwrite      in   1                      1=write, 0=read
//  pwdata      in   DATA_WIDTH             write data
//  pstrb       in   DATA_WIDTH/8           byte write strobes
//  pready      out  1                      transfer complete
//  prdata      out  DATA_WIDTH             read data, valid when pready & ~pwrite
//  pslverr     out  1                      error, valid when pready
//  hw_status   in   DATA_WIDTH             live value returned by reg 1
//  ctrl_q      out  (NUM_REGS-2)*DATA_WIDTH  regs 2..N-1 flattened, reg 2 at LSBs
//  ctrl_wr     out  NUM_REGS-2             one-cycle pulse per reg on committed write
// BEHAVIOUR
//  - One clock pclk; presetn asynchronous active-low. Reset: state=IDLE, wait cnt=0, ctrl regs=0, ctrl_wr=0.
//    pready/prdata/pslverr are combinational from state and are 0 during reset.
//  - Decode: LSB = $clog2(DATA_WIDTH/8); idx = paddr[LSB +: IDX_W].
//    err = (paddr[LSB-1:0]!=0) | (paddr >> LSB >= NUM_REGS) | (pwrite & idx<2).
//    pstrb==0 on write is legal: no byte changes, no error, ctrl_wr still pulses.
//  - FSM: IDLE, ACCESS.
//    IDLE: on psel & ~penable (setup phase) -> ACCESS, cnt <= WAIT_STATES.
//    ACCESS: pready = (cnt==0). While cnt!=0, cnt decrements each cycle.
//    ACCESS with psel & penable & pready -> IDLE (commit). Back-to-back: the next setup phase is seen in IDLE the following cycle.
//    ACCESS with psel==0 (aborted transfer) -> IDLE: no commit, no ctrl_wr, no error.
//    In IDLE, pready=0 and penable alone is ignored.
//  - Latency: completion WAIT_STATES+1 cycles after setup. WAIT_STATES=0 gives pready=1 in the first access cycle.
//  - pslverr = pready & err; prdata = (pready & ~pwrite & ~err) ? reg[idx] : 0.
//    Reg 1 reads hw_status combinationally in the completion cycle.
//  - Write commit, on the completion edge with pwrite & ~err: byte b of reg idx <= pwdata[8b+:8] where pstrb[b]=1.
//    ctrl_wr[idx-2]=1 for exactly the next cycle. Errored writes change nothing.
//  - paddr/pwrite/pwdata/pstrb are sampled only at completion; they are required stable through access per APB.
//  - Reset asserted mid-transfer: immediate return to reset values; the transfer is lost with no commit.
// TESTING
//  - WAIT_STATES=1; write 0x8 data 0xDEADBEEF pstrb 4'hF -> pready 1 in the 2nd access cycle, pslverr=0,
//    ctrl_q[31:0]=0xDEADBEEF, ctrl_wr[0] pulses 1 cycle.
//  - Read 0x0 -> prdata=ID_VALUE. Read 0x4 with hw_status=0x1234 -> prdata=0x1234. pslverr=0 on both.
//  - Byte strobes: reg2=0xDEADBEEF, write 0x8 data 0x00AA0055 pstrb 4'b0101 -> reg2=0xDEAA BE55 (0xDEAABE55).
//  - Errors: write 0x0, read 0x20 (NUM_REGS=8), read 0x9 (misaligned) -> each pslverr=1 with pready, prdata=0, no reg change.
//  - Abort and reset: psel drops in the wait cycle -> FSM IDLE, no write. presetn low mid-access -> ctrl_q=0, pready=0.
//  - WAIT_STATES=0, back-to-back writes to 0x8 then 0xC -> each completes in 1 access cycle, both regs updated.

Source files
------------

// File: rtl/apb_regfile_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : apb_regfile_if
// Brief    : APB bus bundle between a requester (master) and apb_regfile (slave)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface apb_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    pnse;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : apb_regfile
// Brief    : APB completer with ID/status/control registers and wait states
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module apb_regfile #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    NUM_REGS    = 8,
   parameter int                    WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'h0A9B_0001)
) (
   input  logic                               pclk,
   input  logic                               presetn,
   apb_regfile_if.slave                       bus,
   input  logic [DATA_WIDTH-1:0]              hw_status,
   output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] ctrl_q,
   output logic [NUM_REGS-3:0]                ctrl_wr
);
   localparam int c_NBYTES = DATA_WIDTH / 8;
   localparam int c_LSB    = $clog2(c_NBYTES);
   localparam int c_IDX_W  = $clog2(NUM_REGS);
   localparam int c_NCTRL  = NUM_REGS - 2;
   localparam int c_CNT_W  = 4;
   localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(WAIT_STATES);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [DATA_WIDTH-1:0] r_ctrl [c_NCTRL];
   logic [c_NCTRL-1:0]    r_ctrl_wr;

   logic [ADDR_WIDTH-1:0] w_word;
   logic [c_IDX_W-1:0]    w_idx;
   logic                  w_misalign;
   logic                  w_oor;
   logic                  w_err;
   logic                  w_pready;
   logic                  w_commit;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_unused;

   // Address decode; the full word index is compared so aliases above the bank error out
   assign w_word = bus.paddr >> c_LSB;
   assign w_idx  = bus.paddr[c_LSB +: c_IDX_W];
   assign w_oor  = (w_word >= ADDR_WIDTH'(NUM_REGS));

   generate
      if (c_LSB > 0) begin : g_align
         assign w_misalign = |bus.paddr[c_LSB-1:0];
      end else begin : g_no_align
         assign w_misalign = 1'b0;
      end
   endgenerate

   assign w_err    = w_misalign | w_oor | (bus.pwrite & (w_idx < c_IDX_W'(2)));
   assign w_pready = (r_state == S_ACCESS) && (r_cnt == '0);
   assign w_commit = w_pready & bus.psel & bus.penable & bus.pwrite & ~w_err;

   always_comb begin
      w_rdata = '0;
      if (w_idx == c_IDX_W'(0)) begin
         w_rdata = ID_VALUE;
      end else if (w_idx == c_IDX_W'(1)) begin
         w_rdata = hw_status;
      end else begin
         for (int r = 0; r < c_NCTRL; r++) begin
            if (w_idx == c_IDX_W'(r + 2)) begin
               w_rdata = r_ctrl[r];
            end
         end
      end
   end

   assign bus.pready  = w_pready;
   assign bus.pslverr = w_pready & w_err;
   assign bus.prdata  = (w_pready & ~bus.pwrite & ~w_err) ? w_rdata : '0;

   // Transfer sequencer; dropping psel during access abandons the transfer
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.psel && !bus.penable) begin
                  r_state <= S_ACCESS;
                  r_cnt   <= c_WAIT_INIT;
               end
            end
            S_ACCESS: begin
               if (!bus.psel) begin
                  r_state <= S_IDLE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end else if (bus.penable) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int r = 0; r < c_NCTRL; r++) begin
            r_ctrl[r] <= '0;
         end
         r_ctrl_wr <= '0;
      end else begin
         r_ctrl_wr <= '0;
         for (int r = 0; r < c_NCTRL; r++) begin
            if (w_commit && (w_idx == c_IDX_W'(r + 2))) begin
               r_ctrl_wr[r] <= 1'b1;
               for (int b = 0; b < c_NBYTES; b++) begin
                  if (bus.pstrb[b]) begin
                     r_ctrl[r][8*b +: 8] <= bus.pwdata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < c_NCTRL; g++) begin : g_ctrl_out
         assign ctrl_q[g*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[g];
      end
   endgenerate

   assign ctrl_wr  = r_ctrl_wr;
   assign w_unused = ^{bus.pprot, bus.pnse};

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_apb_regfile
// Brief    : directed bench for apb_regfile with 1 and 0 wait-state instances
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_apb_regfile;
   logic         pclk      = 1'b0;
   logic         presetn   = 1'b0;
   logic         sel0      = 1'b0;
   logic [31:0]  paddr     = '0;
   logic [31:0]  pwdata    = '0;
   logic [3:0]   pstrb     = '0;
   logic         psel      = 1'b0;
   logic         penable   = 1'b0;
   logic         pwrite    = 1'b0;
   logic [31:0]  hw_status = 32'h0000_1234;

   logic [191:0] ctrl_q1, ctrl_q0, w_ctrl_q;
   logic [5:0]   ctrl_wr1, ctrl_wr0, w_ctrl_wr;
   logic         w_pready, w_pslverr;
   logic [31:0]  w_prdata;

   int           n_chk = 0;
   int           n_err = 0;
   logic [31:0]  rd;
   logic         er;
   int           cy;

   apb_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
   apb_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

   assign bus1.paddr   = paddr;
   assign bus1.pprot   = 3'b000;
   assign bus1.pnse    = 1'b0;
   assign bus1.psel    = psel & ~sel0;
   assign bus1.penable = penable;
   assign bus1.pwrite  = pwrite;
   assign bus1.pwdata  = pwdata;
   assign bus1.pstrb   = pstrb;

   assign bus0.paddr   = paddr;
   assign bus0.pprot   = 3'b000;
   assign bus0.pnse    = 1'b0;
   assign bus0.psel    = psel & sel0;
   assign bus0.penable = penable;
   assign bus0.pwrite  = pwrite;
   assign bus0.pwdata  = pwdata;
   assign bus0.pstrb   = pstrb;

   assign w_pready  = sel0 ? bus0.pready  : bus1.pready;
   assign w_pslverr = sel0 ? bus0.pslverr : bus1.pslverr;
   assign w_prdata  = sel0 ? bus0.prdata  : bus1.prdata;
   assign w_ctrl_q  = sel0 ? ctrl_q0      : ctrl_q1;
   assign w_ctrl_wr = sel0 ? ctrl_wr0     : ctrl_wr1;

   apb_regfile #(.NUM_REGS(8), .WAIT_STATES(1)) u_dut_w1 (
      .pclk      (pclk),
      .presetn   (presetn),
      .bus       (bus1),
      .hw_status (hw_status),
      .ctrl_q    (ctrl_q1),
      .ctrl_wr   (ctrl_wr1)
   );

   apb_regfile #(.NUM_REGS(8), .WAIT_STATES(0)) u_dut_w0 (
      .pclk      (pclk),
      .presetn   (presetn),
      .bus       (bus0),
      .hw_status (hw_status),
      .ctrl_q    (ctrl_q0),
      .ctrl_wr   (ctrl_wr0)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the completion edge
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output logic slverr, output int cycles);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      rdata   = '0;
      slverr  = 1'b0;
      cycles  = 0;
      step();
      penable = 1'b1;
      forever begin
         @(negedge pclk);
         cycles++;
         if (w_pready) begin
            rdata  = w_prdata;
            slverr = w_pslverr;
            break;
         end
         if (cycles >= 20) begin
            chk("xfer_timeout", 64'd1, 64'd0);
            break;
         end
      end
      step();
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_pready",  {63'd0, w_pready},  64'd0);
      chk("rst_pslverr", {63'd0, w_pslverr}, 64'd0);
      chk("rst_prdata",  {32'd0, w_prdata},  64'd0);
      chk("rst_ctrl_q",  {63'd0, |w_ctrl_q}, 64'd0);
      chk("rst_ctrl_wr", {58'd0, w_ctrl_wr}, 64'd0);
      step();
      presetn = 1'b1;
      step();

      // Full-word write, one wait state
      apb_xfer(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, rd, er, cy);
      chk("wr8_cycles", 64'(cy), 64'd2);
      chk("wr8_pslverr", {63'd0, er}, 64'd0);
      @(negedge pclk);
      chk("wr8_reg2", {32'd0, w_ctrl_q[31:0]}, 64'hDEAD_BEEF);
      chk("wr8_wr_pulse", {58'd0, w_ctrl_wr}, 64'h01);
      @(negedge pclk);
      chk("wr8_wr_drop", {58'd0, w_ctrl_wr}, 64'h00);
      step();

      // ID and live status reads
      apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, cy);
      chk("rd_id", {32'd0, rd}, 64'h0A9B_0001);
      chk("rd_id_err", {63'd0, er}, 64'd0);
      apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, cy);
      chk("rd_status", {32'd0, rd}, 64'h0000_1234);
      chk("rd_status_err", {63'd0, er}, 64'd0);

      // Byte strobes
      apb_xfer(1'b1, 32'h8, 32'h00AA_0055, 4'b0101, rd, er, cy);
      chk("strb_err", {63'd0, er}, 64'd0);
      apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, cy);
      chk("strb_readback", {32'd0, rd}, 64'hDEAA_BE55);

      // Slave errors
      apb_xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, cy);
      chk("err_wr_ro", {63'd0, er}, 64'd1);
      @(negedge pclk);
      chk("err_wr_no_pulse", {58'd0, w_ctrl_wr}, 64'h00);
      step();
      apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, cy);
      chk("err_rd_oor", {63'd0, er}, 64'd1);
      chk("err_rd_oor_data", {32'd0, rd}, 64'd0);
      apb_xfer(1'b0, 32'h9, 32'h0, 4'h0, rd, er, cy);
      chk("err_rd_misalign", {63'd0, er}, 64'd1);
      chk("err_rd_misalign_data", {32'd0, rd}, 64'd0);
      apb_xfer(1'b1, 32'hE, 32'h1234_5678, 4'hF, rd, er, cy);
      chk("err_wr_misalign", {63'd0, er}, 64'd1);
      chk("err_reg2_kept", {32'd0, w_ctrl_q[31:0]}, 64'hDEAA_BE55);
      chk("err_reg3_kept", {32'd0, w_ctrl_q[63:32]}, 64'd0);

      // Zero strobes: legal, no data change, pulse still fires
      apb_xfer(1'b1, 32'hC, 32'hFFFF_FFFF, 4'h0, rd, er, cy);
      chk("strb0_err", {63'd0, er}, 64'd0);
      @(negedge pclk);
      chk("strb0_pulse", {58'd0, w_ctrl_wr}, 64'h02);
      chk("strb0_reg3", {32'd0, w_ctrl_q[63:32]}, 64'd0);
      step();

      // Last register
      apb_xfer(1'b1, 32'h1C, 32'h5A5A_5A5A, 4'hF, rd, er, cy);
      @(negedge pclk);
      chk("last_pulse", {58'd0, w_ctrl_wr}, 64'h20);
      chk("last_reg7", {32'd0, w_ctrl_q[191:160]}, 64'h5A5A_5A5A);
      step();

      // Abort: psel drops during the wait cycle
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h10; pwdata = 32'h1111_1111; pstrb = 4'hF;
      step();
      penable = 1'b1;
      @(negedge pclk);
      chk("abort_wait", {63'd0, w_pready}, 64'd0);
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      chk("abort_idle", {63'd0, w_pready}, 64'd0);
      chk("abort_no_pulse", {58'd0, w_ctrl_wr}, 64'h00);
      chk("abort_reg4", {32'd0, w_ctrl_q[95:64]}, 64'd0);
      step();
      apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, cy);
      chk("abort_rd_cycles", 64'(cy), 64'd2);
      chk("abort_rd_reg4", {32'd0, rd}, 64'd0);

      // Reset asserted mid-access
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h8; pwdata = 32'h2222_2222; pstrb = 4'hF;
      step();
      penable = 1'b1;
      @(negedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      chk("rstmid_pready", {63'd0, w_pready}, 64'd0);
      chk("rstmid_reg2", {32'd0, w_ctrl_q[31:0]}, 64'd0);
      chk("rstmid_reg7", {32'd0, w_ctrl_q[191:160]}, 64'd0);
      psel = 1'b0; penable = 1'b0;
      step();
      presetn = 1'b1;
      step();

      // Zero wait states, back-to-back writes
      sel0 = 1'b1;
      apb_xfer(1'b1, 32'h8, 32'h0102_0304, 4'hF, rd, er, cy);
      chk("b2b_a_cycles", 64'(cy), 64'd1);
      apb_xfer(1'b1, 32'hC, 32'hA5A5_A5A5, 4'hF, rd, er, cy);
      chk("b2b_b_cycles", 64'(cy), 64'd1);
      chk("b2b_reg2", {32'd0, w_ctrl_q[31:0]}, 64'h0102_0304);
      chk("b2b_reg3", {32'd0, w_ctrl_q[63:32]}, 64'hA5A5_A5A5);
      apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, cy);
      chk("ws0_rd_reg3", {32'd0, rd}, 64'hA5A5_A5A5);
      chk("ws0_rd_cycles", 64'(cy), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
